frame_gen: RTL

FRAME_GEN -- requirements
Module: frame_gen

---
 rtl/frame_gen_pkg.sv | 18 +
 rtl/frame_gen_counter.sv | 36 +++
 rtl/frame_gen.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/frame_gen_pkg.sv
// frame_gen_pkg
//   Shared helper for the frame generator slice: the log2 function used to
//   size index and timer registers from their parameters.
package frame_gen_pkg;

    // Ceiling log2, never less than 1 so a one-state counter still has a bit.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/frame_gen_counter.sv
// counter
//   Up counter with synchronous clear and increment enable.  At MAX it either
//   wraps to zero (WRAPAROUND=1) or holds (WRAPAROUND=0).
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, count -> 0
//     clr    synchronous clear (has priority over inc)
//     inc    advance by one
//     count  current value
module counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX        = 255,
    parameter bit          WRAPAROUND = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            if (count == WIDTH'(MAX)) begin
                count <= WRAPAROUND ? '0 : count;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_gen.sv
// frame_gen
//   Groups a free-running, non-back-pressurable sample stream into frames of
//   LENGTH samples, tags each output with its index and first/last flags, and
//   optionally inserts GAP idle cycles between frames.  A sample arriving
//   while the output register is still held is dropped and recorded in a
//   sticky overflow flag.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     enable          level; framing allowed, stop only at a frame boundary
//     clr_ovf         pulse; clears overflow (a coincident drop wins)
//     s_data/s_valid  incoming sample stream
//     m_data/m_valid/m_ready  registered output handshake
//     m_first/m_last  frame boundary flags; m_index position in frame
//     overflow        sticky drop indicator
//     busy            state is not IDLE
module frame_gen
    import frame_gen_pkg::*;
#(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned LENGTH = 64,
    parameter  int unsigned GAP    = 0,
    localparam int unsigned IDX_W  = log2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clr_ovf,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_first,
    output logic              m_last,
    output logic [IDX_W-1:0]  m_index,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned GAP_MAX = (GAP > 0) ? GAP - 1 : 0;
    localparam int unsigned GAP_W   = log2(GAP_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0] idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             idx_last;
    logic             gap_done;
    logic             accept;
    logic             drop;

    assign idx_last = (idx == IDX_W'(LENGTH - 1));
    assign gap_done = (gap_cnt == GAP_W'(GAP_MAX));

    // Index wraps on its own after the last sample, so a new frame always
    // starts at 0; the clear in IDLE only matters after an abandoned frame.
    counter #(
        .WIDTH      (IDX_W),
        .MAX        (LENGTH - 1),
        .WRAPAROUND (1'b1)
    ) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == ST_IDLE),
        .inc   (accept),
        .count (idx)
    );

    // Held at zero outside GAP, so the first GAP cycle sees 0 and the state
    // lasts exactly GAP cycles.
    counter #(
        .WIDTH      (GAP_W),
        .MAX        (GAP_MAX),
        .WRAPAROUND (1'b0)
    ) u_gap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != ST_GAP),
        .inc   (state == ST_GAP),
        .count (gap_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && idx_last) begin
                    if (GAP > 0) begin
                        state_next = ST_GAP;
                    end else if (!enable) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_next = enable ? ST_RUN : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output/decode logic
    always_comb begin
        busy   = (state != ST_IDLE);
        accept = 1'b0;
        drop   = 1'b0;
        if (state == ST_RUN && s_valid) begin
            // The register is free if empty or being drained this cycle.
            if (!m_valid || m_ready) begin
                accept = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_first <= 1'b0;
            m_last  <= 1'b0;
            m_index <= '0;
        end else if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_first <= (idx == '0);
            m_last  <= idx_last;
            m_index <= idx;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Sticky overflow: a new drop takes priority over a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
